// File: rtl/branch_pkg.sv
// Shared encodings for the branch-condition path: operation codes carried in
// cond[2:0], the operand-select bit position and the stored-flag bit layout.
package branch_pkg;

   localparam logic [2:0] OP_EQ   = 3'b000;
   localparam logic [2:0] OP_NE   = 3'b001;
   localparam logic [2:0] OP_GTU  = 3'b010;
   localparam logic [2:0] OP_LTU  = 3'b011;
   localparam logic [2:0] OP_GTS  = 3'b100;
   localparam logic [2:0] OP_LTS  = 3'b101;
   localparam logic [2:0] OP_FLAG = 3'b110;
   localparam logic [2:0] OP_LOOP = 3'b111;

   // cond[OPSEL_BIT] = 1 selects the immediate N as operand B
   localparam int OPSEL_BIT = 3;

   localparam int FLAG_EQ  = 0;
   localparam int FLAG_LTU = 1;
   localparam int FLAG_LTS = 2;

endpackage

// File: rtl/cmp_eval.sv
// Combinational comparator: equality, unsigned less-than and two's-complement
// less-than of operand A against operand B.
module cmp_eval #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             eq,
   output logic             ltu,
   output logic             lts
);

   assign eq  = (a == b);
   assign ltu = (a < b);
   assign lts = ($signed(a) < $signed(b));

endmodule

// File: rtl/branch_cond_unit.sv
// Registered branch-condition unit: compares, stored-flag tests and a
// decrement-and-branch loop counter, answering one cycle after each request.
module branch_cond_unit
   import branch_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             valid_in,
   input  logic [3:0]       cond,
   input  logic             set_flags,
   input  logic [WIDTH-1:0] rddata,
   input  logic [WIDTH-1:0] rsdata,
   input  logic [WIDTH-1:0] N,
   output logic             valid_out,
   output logic             jump,
   output logic [2:0]       flags,
   output logic [WIDTH-1:0] loop_cnt
);

   // Handshake: a request is accepted on every rising edge where valid_in is
   // high and reset is low; valid_out/jump for it are presented for exactly the
   // following cycle. There is no ready signal, the unit never stalls.

   logic [WIDTH-1:0] opb;
   logic             eq, ltu, lts;
   logic [2:0]       live_flags;
   logic [2:0]       op;
   logic             take;
   logic             cnt_we;
   logic [WIDTH-1:0] cnt_next;

   assign opb = cond[OPSEL_BIT] ? N : rsdata;
   assign op  = cond[2:0];

   cmp_eval #(.WIDTH(WIDTH)) u_cmp (
      .a   (rddata),
      .b   (opb),
      .eq  (eq),
      .ltu (ltu),
      .lts (lts)
   );

   always_comb begin
      live_flags           = 3'b000;
      live_flags[FLAG_EQ]  = eq;
      live_flags[FLAG_LTU] = ltu;
      live_flags[FLAG_LTS] = lts;
   end

   always_comb begin
      take     = 1'b0;
      cnt_we   = 1'b0;
      cnt_next = loop_cnt;
      case (op)
         OP_EQ:   take = eq;
         OP_NE:   take = !eq;
         OP_GTU:  take = !eq && !ltu;
         OP_LTU:  take = ltu;
         OP_GTS:  take = !eq && !lts;
         OP_LTS:  take = lts;
         // FLAG reads the stored register, so a same-request capture is not seen
         OP_FLAG: take = cond[OPSEL_BIT] ? flags[FLAG_LTS] : flags[FLAG_EQ];
         OP_LOOP: begin
            cnt_we = 1'b1;
            if (cond[OPSEL_BIT]) begin
               cnt_next = N;
            end else begin
               cnt_next = loop_cnt - WIDTH'(1);
               take     = |cnt_next;
            end
         end
         default: take = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_out <= 1'b0;
         jump      <= 1'b0;
         flags     <= 3'b000;
         loop_cnt  <= '0;
      end else begin
         valid_out <= valid_in;
         jump      <= valid_in && take;
         if (valid_in && set_flags) begin
            flags <= live_flags;
         end
         if (valid_in && cnt_we) begin
            loop_cnt <= cnt_next;
         end
      end
   end

endmodule

// File: tb/tb_branch_cond_unit.sv
// Bench for branch_cond_unit: directed steps plus random requests against an
// arithmetic reference model, on a 16-bit and an 8-bit instance.
module tb_branch_cond_unit;

   logic        clk;
   logic        reset;

   logic        valid_in, set_flags;
   logic [3:0]  cond;
   logic [15:0] rddata, rsdata, n;
   logic        valid_out, jump;
   logic [2:0]  flags;
   logic [15:0] loop_cnt;

   logic        v8_in, sf8;
   logic [3:0]  cond8;
   logic [7:0]  rd8, rs8, n8;
   logic        v8_out, jump8;
   logic [2:0]  flags8;
   logic [7:0]  cnt8;

   int total = 0;
   int bad   = 0;

   logic        exp_q[$];
   logic        exp8_q[$];
   logic [2:0]  m_flags, m8_flags;
   longint unsigned m_cnt, m8_cnt;

   branch_cond_unit #(.WIDTH(16)) dut16 (
      .clk(clk), .reset(reset), .valid_in(valid_in), .cond(cond),
      .set_flags(set_flags), .rddata(rddata), .rsdata(rsdata), .N(n),
      .valid_out(valid_out), .jump(jump), .flags(flags), .loop_cnt(loop_cnt)
   );

   branch_cond_unit #(.WIDTH(8)) dut8 (
      .clk(clk), .reset(reset), .valid_in(v8_in), .cond(cond8),
      .set_flags(sf8), .rddata(rd8), .rsdata(rs8), .N(n8),
      .valid_out(v8_out), .jump(jump8), .flags(flags8), .loop_cnt(cnt8)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Reference model: operands as plain integers, signed view derived by offset.
   function automatic void model(input int w, input logic [3:0] c,
                                 input longint unsigned a, input longint unsigned rs,
                                 input longint unsigned nn, input logic [2:0] fl,
                                 input longint unsigned cnt, output logic j,
                                 output logic [2:0] live, output longint unsigned cnt_o);
      longint unsigned m, b;
      longint sa, sb;
      m  = 64'd1 << w;
      b  = c[3] ? nn : rs;
      sa = (a >= m / 2) ? longint'(a) - longint'(m) : longint'(a);
      sb = (b >= m / 2) ? longint'(b) - longint'(m) : longint'(b);
      live  = {sa < sb, a < b, a == b};
      cnt_o = cnt;
      j     = 1'b0;
      case (c[2:0])
         3'd0: j = (a == b);
         3'd1: j = (a != b);
         3'd2: j = (a > b);
         3'd3: j = (a < b);
         3'd4: j = (sa > sb);
         3'd5: j = (sa < sb);
         3'd6: j = c[3] ? fl[2] : fl[0];
         default: begin
            if (c[3]) begin
               cnt_o = nn;
            end else begin
               cnt_o = (cnt + m - 1) % m;
               j     = (cnt_o != 0);
            end
         end
      endcase
   endfunction

   // driver: one 16-bit request (or idle when v = 0), then check its result
   task automatic step16(input string tag, input logic v, input logic [3:0] c,
                         input logic sf, input logic [15:0] a, input logic [15:0] rs,
                         input logic [15:0] nn);
      logic j;
      logic [2:0] live;
      longint unsigned nc;
      logic expj;
      valid_in = v; cond = c; set_flags = sf; rddata = a; rsdata = rs; n = nn;
      v8_in = 1'b0;
      model(16, c, a, rs, nn, m_flags, m_cnt, j, live, nc);
      if (v) begin
         exp_q.push_back(j);
         m_cnt = nc;
         if (sf) m_flags = live;
      end
      @(posedge clk); #1;
      chk({tag, ".valid"}, 64'(valid_out), 64'(v));
      expj = 1'b0;
      if (v && exp_q.size() > 0) expj = exp_q.pop_front();
      chk({tag, ".jump"}, 64'(jump), 64'(expj));
      chk({tag, ".flags"}, 64'(flags), 64'(m_flags));
      chk({tag, ".cnt"}, 64'(loop_cnt), m_cnt);
   endtask

   task automatic step8(input string tag, input logic v, input logic [3:0] c,
                        input logic sf, input logic [7:0] a, input logic [7:0] rs,
                        input logic [7:0] nn);
      logic j;
      logic [2:0] live;
      longint unsigned nc;
      logic expj;
      v8_in = v; cond8 = c; sf8 = sf; rd8 = a; rs8 = rs; n8 = nn;
      valid_in = 1'b0;
      model(8, c, a, rs, nn, m8_flags, m8_cnt, j, live, nc);
      if (v) begin
         exp8_q.push_back(j);
         m8_cnt = nc;
         if (sf) m8_flags = live;
      end
      @(posedge clk); #1;
      chk({tag, ".valid"}, 64'(v8_out), 64'(v));
      expj = 1'b0;
      if (v && exp8_q.size() > 0) expj = exp8_q.pop_front();
      chk({tag, ".jump"}, 64'(jump8), 64'(expj));
      chk({tag, ".flags"}, 64'(flags8), 64'(m8_flags));
      chk({tag, ".cnt"}, 64'(cnt8), m8_cnt);
   endtask

   task automatic model_reset();
      m_flags = 3'b000; m_cnt = 0; m8_flags = 3'b000; m8_cnt = 0;
      exp_q.delete(); exp8_q.delete();
   endtask

   initial begin
      model_reset();
      // a request held during reset must be discarded by both instances
      reset = 1'b1;
      valid_in = 1'b1; cond = 4'b0000; set_flags = 1'b1;
      rddata = 16'h0042; rsdata = 16'h0042; n = 16'h0000;
      v8_in = 1'b1; cond8 = 4'b1111; sf8 = 1'b1; rd8 = 8'h10; rs8 = 8'h10; n8 = 8'h05;
      repeat (2) @(posedge clk);
      #1;
      chk("rst.valid", 64'(valid_out), 64'(0));
      chk("rst.jump", 64'(jump), 64'(0));
      chk("rst.flags", 64'(flags), 64'(0));
      chk("rst.cnt", 64'(loop_cnt), 64'(0));
      chk("rst.cnt8", 64'(cnt8), 64'(0));
      reset = 1'b0;
      step16("post_rst", 1'b0, 4'b0000, 1'b0, 16'h0, 16'h0, 16'h0);

      // back-to-back compares against N
      step16("gtu", 1'b1, 4'b1010, 1'b0, 16'hFFFE, 16'h0, 16'h0001);
      step16("gts", 1'b1, 4'b1100, 1'b0, 16'hFFFE, 16'h0, 16'h0001);
      step16("lts", 1'b1, 4'b1101, 1'b0, 16'hFFFE, 16'h0, 16'h0001);

      // loop counter: load, djnz down through zero and wrap
      step16("load", 1'b1, 4'b1111, 1'b0, 16'h0, 16'h0, 16'h0003);
      for (int i = 0; i < 4; i++) begin
         step16($sformatf("djnz%0d", i), 1'b1, 4'b0111, 1'b0, 16'h0, 16'h0, 16'h0);
      end
      chk("wrap.cnt", 64'(loop_cnt), 64'hFFFF);

      // stored flags and same-request flag test
      step16("setf", 1'b1, 4'b0000, 1'b1, 16'h1234, 16'h1234, 16'h0);
      chk("setf.flags", 64'(flags), 64'(3'b001));
      step16("flag_eq", 1'b1, 4'b0110, 1'b1, 16'd5, 16'd7, 16'h0);
      chk("flag_eq.flags", 64'(flags), 64'(3'b110));
      step16("flag_lts", 1'b1, 4'b1110, 1'b0, 16'd0, 16'd0, 16'h0);
      step16("sf_novalid", 1'b0, 4'b0000, 1'b1, 16'd9, 16'd9, 16'h0);
      step16("idle", 1'b0, 4'b0000, 1'b0, 16'd0, 16'd0, 16'h0);

      // legacy forms
      step16("zero", 1'b1, 4'b1000, 1'b0, 16'h0000, 16'h0, 16'h0000);
      step16("nonzero", 1'b1, 4'b1000, 1'b0, 16'h0100, 16'h0, 16'h0000);
      step16("neg", 1'b1, 4'b1101, 1'b0, 16'h8000, 16'h0, 16'h0000);
      step16("ones", 1'b1, 4'b1000, 1'b0, 16'hFFFF, 16'h0, 16'hFFFF);

      // reset while a result is pending
      step16("pend", 1'b1, 4'b0001, 1'b1, 16'h0001, 16'h0002, 16'h0);
      reset = 1'b1; valid_in = 1'b0;
      @(posedge clk); #1;
      model_reset();
      chk("pend_rst.valid", 64'(valid_out), 64'(0));
      chk("pend_rst.flags", 64'(flags), 64'(0));
      reset = 1'b0;

      // random requests, small operands often so equality and loop codes hit
      for (int i = 0; i < 300; i++) begin
         logic [15:0] a, b, c;
         a = ($urandom_range(0, 1) != 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
         b = ($urandom_range(0, 1) != 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
         c = ($urandom_range(0, 1) != 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
         step16("rnd", 1'($urandom_range(0, 3) != 0), 4'($urandom), 1'($urandom),
                a, b, c);
      end

      // 8-bit instance
      step8("w8_lts", 1'b1, 4'b1101, 1'b0, 8'h80, 8'h00, 8'h00);
      step8("w8_ltu", 1'b1, 4'b1011, 1'b0, 8'h80, 8'h00, 8'h00);
      step8("w8_load", 1'b1, 4'b1111, 1'b0, 8'h00, 8'h00, 8'h01);
      step8("w8_djnz1", 1'b1, 4'b0111, 1'b0, 8'h00, 8'h00, 8'h00);
      step8("w8_djnz0", 1'b1, 4'b0111, 1'b0, 8'h00, 8'h00, 8'h00);
      chk("w8_wrap.cnt", 64'(cnt8), 64'hFF);
      for (int i = 0; i < 150; i++) begin
         logic [7:0] a, b, c;
         a = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(126, 129)) : 8'($urandom);
         b = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(126, 129)) : 8'($urandom);
         c = 8'($urandom_range(0, 2));
         step8("rnd8", 1'($urandom_range(0, 3) != 0), 4'($urandom), 1'($urandom),
               a, b, c);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
